sd_spi_master: RTL and testbench

SD_SPI_MASTER -- requirements
Module: sd_spi_master

---
 rtl/sd_spi_master.sv | 163 ++++++++++++++++
 tb/tb_sd_spi_master.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_master.sv
// SD-card SPI master: 80-clock init sequence, mode-0 byte transfers, CS control, idle timeout.
// Byte transfer: 16*SPI_DIV cycles; init: 160*INIT_DIV cycles; sd_busy/sd_din are registered.
// Strobes are only accepted in IDLE; strobes arriving while busy are dropped without side effects.
module sd_spi_master #(
  parameter int          SPI_DIV  = 2,
  parameter int          INIT_DIV = 64,
  parameter logic [23:0] TIMEOUT  = 24'd3500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sd_signal,
  input  logic [1:0] sd_cmd,
  input  logic [7:0] sd_out,
  output logic [7:0] sd_din,
  output logic       sd_busy,
  output logic       sd_timeout,
  output logic       spi_cs,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_XFER = 2'd2
  } state_t;

  localparam logic [15:0] SPI_LAST  = 16'(SPI_DIV - 1);
  localparam logic [15:0] INIT_LAST = 16'(INIT_DIV - 1);
  // Half-period index of the final falling edge for each mode.
  localparam logic [7:0]  XFER_HP_LAST = 8'd15;
  localparam logic [7:0]  INIT_HP_LAST = 8'd159;

  state_t      state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [7:0]  hp_q, hp_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  din_q, din_d;
  logic [23:0] tmo_q, tmo_d;
  logic        busy_q, busy_d;
  logic        cs_q, cs_d;
  logic        sclk_q, sclk_d;

  logic        accept;
  logic        half_end;
  logic [7:0]  hp_last;

  assign accept   = sd_signal && (state_q == S_IDLE);
  assign half_end = (div_q == ((state_q == S_INIT) ? INIT_LAST : SPI_LAST));
  assign hp_last  = (state_q == S_INIT) ? INIT_HP_LAST : XFER_HP_LAST;

  // State and datapath registers; reset returns everything to a quiet idle bus.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      hp_q    <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      din_q   <= 8'hFF;
      tmo_q   <= '0;
      busy_q  <= 1'b0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      hp_q    <= hp_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      din_q   <= din_d;
      tmo_q   <= tmo_d;
      busy_q  <= busy_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
    end
  end

  // Next-state logic: command decode in IDLE, SCLK generation and shifting while active.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    hp_d    = hp_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    din_d   = din_q;
    tmo_d   = tmo_q;
    busy_d  = busy_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;

    case (state_q)
      S_IDLE: begin
        sclk_d = 1'b0;
        if (tmo_q != TIMEOUT) begin
          tmo_d = tmo_q + 24'd1;
        end
        if (accept) begin
          tmo_d = '0;
          case (sd_cmd)
            2'd0: begin
              state_d = S_INIT;
              busy_d  = 1'b1;
              cs_d    = 1'b1;
              div_d   = '0;
              hp_d    = '0;
            end
            2'd1: begin
              state_d = S_XFER;
              busy_d  = 1'b1;
              tx_d    = sd_out;
              div_d   = '0;
              hp_d    = '0;
            end
            2'd2:    cs_d = 1'b0;
            default: cs_d = 1'b1;
          endcase
        end
      end

      S_INIT, S_XFER: begin
        if (half_end) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          // Even half-periods end on a rising edge (sample), odd ones on a falling edge (shift).
          if (state_q == S_XFER) begin
            if (!hp_q[0]) begin
              rx_d = {rx_q[6:0], spi_miso};
            end else begin
              tx_d = {tx_q[6:0], 1'b1};
            end
          end
          if (hp_q == hp_last) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            sclk_d  = 1'b0;
            hp_d    = '0;
            if (state_q == S_XFER) begin
              din_d = rx_q;
            end
          end else begin
            hp_d = hp_q + 8'd1;
          end
        end else begin
          div_d = div_q + 16'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // MOSI follows the shift register MSB only during a byte transfer; the line idles high.
  assign spi_mosi   = (state_q == S_XFER) ? tx_q[7] : 1'b1;
  assign spi_sclk   = sclk_q;
  assign spi_cs     = cs_q;
  assign sd_busy    = busy_q;
  assign sd_din     = din_q;
  assign sd_timeout = (tmo_q == TIMEOUT);

endmodule

// File: tb/tb_sd_spi_master.sv
module tb_sd_spi_master;

  logic       clock = 1'b0;
  logic       reset;
  logic       sd_signal;
  logic [1:0] sd_cmd;
  logic [7:0] sd_out;
  logic [7:0] sd_din;
  logic       sd_busy;
  logic       sd_timeout;
  logic       spi_cs;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso;

  int tests = 0;
  int fails = 0;

  sd_spi_master #(
    .SPI_DIV (2),
    .INIT_DIV(4),
    .TIMEOUT (24'd100)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .sd_signal (sd_signal),
    .sd_cmd    (sd_cmd),
    .sd_out    (sd_out),
    .sd_din    (sd_din),
    .sd_busy   (sd_busy),
    .sd_timeout(sd_timeout),
    .spi_cs    (spi_cs),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one strobe, then follow the transfer (if any) cycle by cycle at negedges.
  task automatic run_cmd(input logic [1:0] cmd, input logic [7:0] tx, input logic [7:0] rxp,
                         input bit inject,
                         output logic [7:0] mbits, output int rises, output int cyc,
                         output bit cs_lo_seen, output bit cs_hi_seen, output bit mosi0_seen,
                         output bit din_moved, output logic [7:0] din_end);
    logic       prev;
    bit         inj_done;
    logic [7:0] din0;
    @(negedge clock);
    sd_cmd    = cmd;
    sd_out    = tx;
    sd_signal = 1'b1;
    spi_miso  = rxp[7];
    rises = 0; cyc = 0; mbits = '0;
    cs_lo_seen = 0; cs_hi_seen = 0; mosi0_seen = 0; din_moved = 0;
    prev = 1'b0; inj_done = 0;
    @(negedge clock);
    sd_signal = 1'b0;
    din0 = sd_din;
    while (sd_busy === 1'b1 && cyc < 2000) begin
      cyc++;
      sd_signal = 1'b0;
      if (spi_cs !== 1'b1) cs_lo_seen = 1;
      if (spi_cs !== 1'b0) cs_hi_seen = 1;
      if (spi_mosi !== 1'b1) mosi0_seen = 1;
      if (sd_din !== din0) din_moved = 1;
      if (spi_sclk === 1'b1 && prev === 1'b0) begin
        mbits = {mbits[6:0], spi_mosi};
        rises++;
        if (rises < 8) spi_miso = rxp[3'(7 - rises)];
      end
      if (inject && !inj_done && rises == 4) begin
        sd_cmd    = 2'd3;
        sd_out    = 8'h00;
        sd_signal = 1'b1;
        inj_done  = 1;
      end
      prev = spi_sclk;
      @(negedge clock);
    end
    sd_signal = 1'b0;
    din_end = sd_din;
  endtask

  logic [7:0] mbits, din_end;
  int         rises, cyc, n, r;
  bit         cs_lo, cs_hi, mosi0, din_mv;
  logic       prev;

  initial begin
    reset = 1'b1; sd_signal = 1'b0; sd_cmd = 2'd0; sd_out = 8'h00; spi_miso = 1'b0;
    repeat (3) @(negedge clock);

    // Reset state
    chk("rst_busy", 32'(sd_busy), 32'h0);
    chk("rst_timeout", 32'(sd_timeout), 32'h0);
    chk("rst_din", 32'(sd_din), 32'hFF);
    chk("rst_cs", 32'(spi_cs), 32'h1);
    chk("rst_sclk", 32'(spi_sclk), 32'h0);
    chk("rst_mosi", 32'(spi_mosi), 32'h1);

    // Idle timeout: asserts after exactly 100 posedges, holds, clears after a cmd 2
    reset = 1'b0;
    repeat (99) @(negedge clock);
    chk("tmo_at_99", 32'(sd_timeout), 32'h0);
    @(negedge clock);
    chk("tmo_at_100", 32'(sd_timeout), 32'h1);
    repeat (20) @(negedge clock);
    chk("tmo_saturated", 32'(sd_timeout), 32'h1);
    run_cmd(2'd2, 8'h00, 8'h00, 0, mbits, rises, cyc, cs_lo, cs_hi, mosi0, din_mv, din_end);
    chk("tmo_cleared", 32'(sd_timeout), 32'h0);
    chk("cmd2_cs_low", 32'(spi_cs), 32'h0);
    chk("cmd2_no_busy", 32'(cyc), 32'd0);

    // Byte transfer A5 out, 3C in, CS low
    run_cmd(2'd1, 8'hA5, 8'h3C, 0, mbits, rises, cyc, cs_lo, cs_hi, mosi0, din_mv, din_end);
    chk("x1_mosi_bits", 32'(mbits), 32'hA5);
    chk("x1_rises", 32'(rises), 32'd8);
    chk("x1_busy_cycles", 32'(cyc), 32'd32);
    chk("x1_cs_stayed_low", 32'(cs_hi), 32'h0);
    chk("x1_din_held", 32'(din_mv), 32'h0);
    chk("x1_din", 32'(din_end), 32'h3C);
    chk("x1_idle_sclk", 32'(spi_sclk), 32'h0);
    chk("x1_idle_mosi", 32'(spi_mosi), 32'h1);

    // Init sequence
    run_cmd(2'd0, 8'h00, 8'h00, 0, mbits, rises, cyc, cs_lo, cs_hi, mosi0, din_mv, din_end);
    chk("init_rises", 32'(rises), 32'd80);
    chk("init_busy_cycles", 32'(cyc), 32'd640);
    chk("init_cs_high", 32'(cs_lo), 32'h0);
    chk("init_mosi_high", 32'(mosi0), 32'h0);
    chk("init_cs_after", 32'(spi_cs), 32'h1);
    chk("init_din_kept", 32'(din_end), 32'h3C);

    // Strobe during transfer is ignored
    run_cmd(2'd2, 8'h00, 8'h00, 0, mbits, rises, cyc, cs_lo, cs_hi, mosi0, din_mv, din_end);
    run_cmd(2'd1, 8'hFF, 8'h5A, 1, mbits, rises, cyc, cs_lo, cs_hi, mosi0, din_mv, din_end);
    chk("ign_cs_low", 32'(cs_hi), 32'h0);
    chk("ign_mosi_ones", 32'(mosi0), 32'h0);
    chk("ign_mosi_bits", 32'(mbits), 32'hFF);
    chk("ign_busy_cycles", 32'(cyc), 32'd32);
    chk("ign_din", 32'(din_end), 32'h5A);
    chk("ign_cs_after", 32'(spi_cs), 32'h0);

    // Reset in the middle of a transfer
    @(negedge clock);
    sd_cmd = 2'd1; sd_out = 8'h3C; sd_signal = 1'b1; spi_miso = 1'b1;
    @(negedge clock);
    sd_signal = 1'b0;
    n = 0; r = 0; prev = 1'b0;
    while (r < 4 && n < 500) begin
      if (spi_sclk === 1'b1 && prev === 1'b0) r++;
      prev = spi_sclk;
      if (r < 4) begin
        @(negedge clock);
        n++;
      end
    end
    chk("mid_rises", 32'(r), 32'd4);
    chk("mid_busy_before", 32'(sd_busy), 32'h1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(sd_busy), 32'h0);
    chk("mid_rst_din", 32'(sd_din), 32'hFF);
    chk("mid_rst_cs", 32'(spi_cs), 32'h1);
    chk("mid_rst_sclk", 32'(spi_sclk), 32'h0);
    chk("mid_rst_mosi", 32'(spi_mosi), 32'h1);
    chk("mid_rst_timeout", 32'(sd_timeout), 32'h0);
    @(negedge clock);
    reset = 1'b0;

    run_cmd(2'd1, 8'h81, 8'hC3, 0, mbits, rises, cyc, cs_lo, cs_hi, mosi0, din_mv, din_end);
    chk("post_mosi_bits", 32'(mbits), 32'h81);
    chk("post_rises", 32'(rises), 32'd8);
    chk("post_busy_cycles", 32'(cyc), 32'd32);
    chk("post_din", 32'(din_end), 32'hC3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
